// File: rtl/excess3_pkg.sv
// -----------------------------------------------------------------------------
// excess3_pkg
// Shared constants and types for the Excess-3 decode path.
//   E3_BIAS      : offset added by the Excess-3 code (3)
//   E3_MIN/MAX   : range of legal Excess-3 codes (4'h3..4'hC)
//   BCD_ILLEGAL  : value substituted for a digit whose code was illegal
//   dec_state_t  : states of the streaming decoder FSM
// -----------------------------------------------------------------------------
package excess3_pkg;

   localparam logic [3:0] E3_BIAS     = 4'd3;
   localparam logic [3:0] E3_MIN      = 4'h3;
   localparam logic [3:0] E3_MAX      = 4'hC;
   localparam logic [3:0] BCD_ILLEGAL = 4'hF;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      HOLD    = 2'd1,
      DRAIN   = 2'd2
   } dec_state_t;

endpackage

// File: rtl/excess3_digit_decode.sv
// -----------------------------------------------------------------------------
// excess3_digit_decode
// Purely combinational single-digit Excess-3 to BCD converter.
// Ports:
//   code    in  4  Excess-3 code
//   bcd     out 4  decoded BCD digit, BCD_ILLEGAL when code is out of range
//   illegal out 1  code is outside 4'h3..4'hC
// -----------------------------------------------------------------------------
module excess3_digit_decode
   import excess3_pkg::*;
(
   input  logic [3:0] code,
   output logic [3:0] bcd,
   output logic       illegal
);

   // The modulo-16 subtraction result is only passed through for legal
   // codes; illegal codes are replaced by a fixed marker so a bad digit is
   // always visible in the packed word, not aliased onto a real digit.
   always_comb begin
      illegal = (code < E3_MIN) || (code > E3_MAX);
      bcd     = illegal ? BCD_ILLEGAL : (code - E3_BIAS);
   end

endmodule

// File: rtl/excess3_bcd_decoder.sv
// -----------------------------------------------------------------------------
// excess3_bcd_decoder
// Streaming Excess-3 to packed-BCD decoder. Digits arrive MSD first over a
// valid/ready handshake and are packed right-aligned into one word per
// framed number, presented on a second valid/ready interface.
// Parameters:
//   NDIGITS    maximum digits per output word (>= 1)
// Ports:
//   clk        in  1              rising-edge clock
//   rst_n      in  1              asynchronous active-low reset
//   in_valid   in  1              in_digit / in_last valid
//   in_ready   out 1              decoder accepts a digit this cycle
//   in_digit   in  4              Excess-3 code
//   in_last    in  1              final digit of the number
//   out_valid  out 1              packed word available
//   out_ready  in  1              downstream accepts the word
//   out_bcd    out 4*NDIGITS      packed BCD, right-aligned, upper digits 0
//   out_count  out clog2(N+1)     digits in the word
//   out_err    out 1              word contained an illegal code
//   out_trunc  out 1              word closed at NDIGITS without in_last
// -----------------------------------------------------------------------------
module excess3_bcd_decoder
   import excess3_pkg::*;
#(
   parameter int NDIGITS = 4
)
(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [3:0]                     in_digit,
   input  logic                           in_last,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [4*NDIGITS-1:0]           out_bcd,
   output logic [$clog2(NDIGITS+1)-1:0]   out_count,
   output logic                           out_err,
   output logic                           out_trunc
);

   localparam int CW = $clog2(NDIGITS + 1);
   localparam logic [CW-1:0] MAX_COUNT = CW'(NDIGITS);

   dec_state_t          state;
   dec_state_t          state_next;
   logic [4*NDIGITS-1:0] acc;
   logic [4*NDIGITS-1:0] acc_next;
   logic [4*NDIGITS-1:0] acc_shift;
   logic [CW-1:0]        count;
   logic [CW-1:0]        count_next;
   logic [CW-1:0]        count_inc;
   logic                 err;
   logic                 err_next;
   logic                 trunc;
   logic                 trunc_next;
   logic [3:0]           dec;
   logic                 illegal;

   excess3_digit_decode u_digit_decode (
      .code    (in_digit),
      .bcd     (dec),
      .illegal (illegal)
   );

   // A single-digit word has nothing to shift out of the way, so the
   // accumulator simply takes the new digit.
   generate
      if (NDIGITS == 1) begin : g_single
         assign acc_shift = dec;
      end else begin : g_multi
         assign acc_shift = {acc[4*NDIGITS-5:0], dec};
      end
   endgenerate

   assign count_inc = count + CW'(1);

   // Handshake outputs depend on state only, so no input can reach an
   // output combinationally.
   assign in_ready  = (state != HOLD);
   assign out_valid = (state == HOLD);
   assign out_bcd   = acc;
   assign out_count = count;
   assign out_err   = err;
   assign out_trunc = trunc;

   // Next-state and datapath update. In COLLECT in_ready is 1, so in_valid
   // alone means a digit is accepted. in_last wins over the count limit so
   // a number of exactly NDIGITS digits is not reported as truncated.
   // A truncated word is followed by DRAIN, which swallows the rest of the
   // over-long number up to and including its in_last digit.
   always_comb begin
      state_next = state;
      acc_next   = acc;
      count_next = count;
      err_next   = err;
      trunc_next = trunc;
      case (state)
         COLLECT: begin
            if (in_valid) begin
               acc_next   = acc_shift;
               count_next = count_inc;
               err_next   = err | illegal;
               if (in_last) begin
                  state_next = HOLD;
                  trunc_next = 1'b0;
               end else if (count_inc == MAX_COUNT) begin
                  state_next = HOLD;
                  trunc_next = 1'b1;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               acc_next   = '0;
               count_next = '0;
               err_next   = 1'b0;
               trunc_next = 1'b0;
               state_next = trunc ? DRAIN : COLLECT;
            end
         end
         DRAIN: begin
            if (in_valid && in_last) begin
               state_next = COLLECT;
            end
         end
         default: begin
            state_next = COLLECT;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial or pending word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= COLLECT;
         acc   <= '0;
         count <= '0;
         err   <= 1'b0;
         trunc <= 1'b0;
      end else begin
         state <= state_next;
         acc   <= acc_next;
         count <= count_next;
         err   <= err_next;
         trunc <= trunc_next;
      end
   end

endmodule

// File: tb/tb_excess3_bcd_decoder.sv
// -----------------------------------------------------------------------------
// tb_excess3_bcd_decoder
// Directed bench for excess3_bcd_decoder with NDIGITS = 4, plus a short
// round-trip section that encodes random decimal digits to Excess-3.
// -----------------------------------------------------------------------------
module tb_excess3_bcd_decoder;

   localparam int NDIGITS = 4;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_digit;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_bcd;
   logic [2:0]  out_count;
   logic        out_err;
   logic        out_trunc;

   int testsRun;
   int testsFailed;

   excess3_bcd_decoder #(.NDIGITS(NDIGITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_digit  (in_digit),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bcd   (out_bcd),
      .out_count (out_count),
      .out_err   (out_err),
      .out_trunc (out_trunc)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Present one digit and hold it until accepted; returns 1 time unit
   // after the accepting clock edge with in_valid still asserted.
   task automatic applyStimulus(input logic [3:0] digit, input logic last);
      bit accepted;
      accepted = 1'b0;
      in_valid = 1'b1;
      in_digit = digit;
      in_last  = last;
      for (int c = 0; c < 50 && !accepted; c++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            accepted = 1'b1;
         end
      end
      if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
   endtask

   // Called right after the closing digit was accepted: the word must be
   // valid at the very next sample, then is checked and consumed (with
   // optional random backpressure, during which it must stay stable).
   task automatic checkWord(input string tag, input logic [15:0] expBcd,
                            input logic [2:0] expCount, input logic expErr,
                            input logic expTrunc, input bit stall);
      bit done;
      done     = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      checkOutput({tag, "_bcd"},   {16'd0, out_bcd},   {16'd0, expBcd});
      checkOutput({tag, "_count"}, {29'd0, out_count}, {29'd0, expCount});
      checkOutput({tag, "_err"},   {31'd0, out_err},   {31'd0, expErr});
      checkOutput({tag, "_trunc"}, {31'd0, out_trunc}, {31'd0, expTrunc});
      for (int c = 0; c < 20 && !done; c++) begin
         if (c > 0) checkOutput({tag, "_stable"}, {16'd0, out_bcd}, {16'd0, expBcd});
         if (stall && c < 3) out_ready = 1'($urandom_range(0, 1));
         else                out_ready = 1'b1;
         @(posedge clk);
         #1;
         if (!out_valid) done = 1'b1;
         else            @(negedge clk);
      end
      out_ready = 1'b1;
      if (!done) checkOutput({tag, "_consume_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      logic [15:0] expBcd;
      int          len;
      int          d;

      testsRun    = 0;
      testsFailed = 0;
      rst_n       = 1'b1;
      in_valid    = 1'b0;
      in_digit    = 4'h0;
      in_last     = 1'b0;
      out_ready   = 1'b1;

      // Power-on reset: all outputs at their reset values.
      #3 rst_n = 1'b0;
      #1;
      checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_ready", {31'd0, in_ready},  32'd1);
      checkOutput("rst_bcd",   {16'd0, out_bcd},   32'd0);
      checkOutput("rst_count", {29'd0, out_count}, 32'd0);
      checkOutput("rst_err",   {31'd0, out_err},   32'd0);
      checkOutput("rst_trunc", {31'd0, out_trunc}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic three-digit word: 4,8,C -> 1,5,9.
      applyStimulus(4'h4, 1'b0);
      applyStimulus(4'h8, 1'b0);
      applyStimulus(4'hC, 1'b1);
      checkWord("w159", 16'h0159, 3'd2 + 3'd1, 1'b0, 1'b0, 1'b0);

      // Illegal code marks the word; the flag does not leak to the next one.
      applyStimulus(4'h3, 1'b0);
      applyStimulus(4'hF, 1'b1);
      checkWord("wErr", 16'h000F, 3'd2, 1'b1, 1'b0, 1'b0);
      applyStimulus(4'h7, 1'b1);
      checkWord("wAfterErr", 16'h0004, 3'd1, 1'b0, 1'b0, 1'b0);

      // Low illegal code 4'h0 also flagged.
      applyStimulus(4'h0, 1'b0);
      applyStimulus(4'h5, 1'b1);
      checkWord("wErrLow", 16'h00F2, 3'd2, 1'b1, 1'b0, 1'b0);

      // Exactly NDIGITS digits with last on the 4th: not truncated.
      applyStimulus(4'hC, 1'b0);
      applyStimulus(4'h3, 1'b0);
      applyStimulus(4'hB, 1'b0);
      applyStimulus(4'h4, 1'b1);
      checkWord("wFull", 16'h9081, 3'd4, 1'b0, 1'b0, 1'b0);

      // Six-digit number: truncated word, two digits drained silently.
      applyStimulus(4'h4, 1'b0);
      applyStimulus(4'h5, 1'b0);
      applyStimulus(4'h6, 1'b0);
      applyStimulus(4'h7, 1'b0);
      checkWord("wTrunc", 16'h1234, 3'd4, 1'b0, 1'b1, 1'b0);
      applyStimulus(4'h8, 1'b0);
      checkOutput("drain1_valid", {31'd0, out_valid}, 32'd0);
      applyStimulus(4'h9, 1'b1);
      checkOutput("drain2_valid", {31'd0, out_valid}, 32'd0);
      applyStimulus(4'hC, 1'b1);
      checkWord("wAfterDrain", 16'h0009, 3'd1, 1'b0, 1'b0, 1'b0);

      // Backpressure: word held 5 cycles while upstream keeps a digit pending.
      out_ready = 1'b0;
      applyStimulus(4'h4, 1'b0);
      applyStimulus(4'h5, 1'b1);
      in_digit = 4'h6;
      in_last  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
         checkOutput("bp_ready", {31'd0, in_ready},  32'd0);
         checkOutput("bp_bcd",   {16'd0, out_bcd},   32'h0012);
         checkOutput("bp_count", {29'd0, out_count}, 32'd2);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("bp_release_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("bp_release_ready", {31'd0, in_ready},  32'd1);
      @(posedge clk);
      #1;
      checkWord("wPending", 16'h0003, 3'd1, 1'b0, 1'b0, 1'b0);

      // Reset mid-frame discards the partial word immediately.
      applyStimulus(4'h5, 1'b0);
      applyStimulus(4'h6, 1'b0);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      checkOutput("midrst_bcd",   {16'd0, out_bcd},   32'd0);
      checkOutput("midrst_count", {29'd0, out_count}, 32'd0);
      checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("midrst_ready", {31'd0, in_ready},  32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(4'h3, 1'b1);
      checkWord("wAfterRst", 16'h0000, 3'd1, 1'b0, 1'b0, 1'b0);

      // Round trip: random decimal digits encoded to Excess-3 by the bench,
      // with random backpressure on the output side.
      for (int w = 0; w < 10; w++) begin
         len    = int'($urandom_range(1, NDIGITS));
         expBcd = 16'h0000;
         for (int i = 0; i < len; i++) begin
            d      = int'($urandom_range(0, 9));
            expBcd = {expBcd[11:0], 4'(d)};
            applyStimulus(4'(d + 3), (i == len - 1));
         end
         checkWord("wRand", expBcd, 3'(len), 1'b0, 1'b0, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/excess3_bcd_decoder.md
# excess3_bcd_decoder

Streaming Excess-3 to BCD decoder. It is the receive-side counterpart of the team's BCD-to-Excess-3 encoder. It accepts one Excess-3 digit per cycle, most significant digit first, over a valid/ready handshake. It strips the +3 bias, flags illegal codes, and packs each framed number into a right-aligned packed-BCD word. That word is presented on a second valid/ready interface for display and arithmetic blocks downstream.

## Interface

Parameters:
- NDIGITS, default 4: maximum digits per output word; must be ≥ 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_digit and in_last are valid.
- in_ready  out  1  decoder accepts a digit this cycle.
- in_digit  in  4  Excess-3 code. Legal codes are 4'h3..4'hC.
- in_last  in  1  final digit of the current number.
- out_valid  out  1  packed word available.
- out_ready  in  1  downstream accepts the word.
- out_bcd  out  4*NDIGITS  packed BCD, right-aligned; unused upper digits are 0.
- out_count  out  $clog2(NDIGITS+1)  number of digits in the word (1..NDIGITS).
- out_err  out  1  one or more digits in the word had an illegal code.
- out_trunc  out  1  word was closed at NDIGITS digits without in_last.

## Operation

- Accept rule: a digit is accepted when in_valid && in_ready. A word is consumed when out_valid && out_ready.
- FSM states are COLLECT, HOLD and DRAIN.
- COLLECT:
  - in_ready = 1, out_valid = 0.
  - Each accepted digit does: acc <= {acc[4*NDIGITS-5:0], dec}; count += 1; err |= illegal.
  - dec = in_digit - 4'd3 for legal codes. dec = 4'hF for illegal codes (0,1,2,D,E,F).
  - If the accepted digit has in_last = 1, go to HOLD with trunc = 0.
  - Else if count reaches NDIGITS, go to HOLD with trunc = 1.
  - The in_last case takes priority when both conditions hold on the same digit; trunc = 0 in that case.
- HOLD:
  - in_ready = 0, out_valid = 1.
  - out_bcd, out_count, out_err and out_trunc are stable until the word is consumed.
  - On consume, clear acc, count and err. Go to DRAIN if trunc = 1, otherwise go to COLLECT.
- DRAIN:
  - in_ready = 1, out_valid = 0.
  - Accepted digits are discarded and do not affect err.
  - Accepting a digit with in_last = 1 returns the FSM to COLLECT.
- Words are never empty: out_count ≥ 1 whenever out_valid = 1.
- Arithmetic: the subtraction is modulo 16, but its result is used only for legal codes. acc width is exactly 4*NDIGITS. count saturates by construction because the word closes at NDIGITS.

## Timing

- Reset (asynchronous assert, synchronous-safe deassert): state = COLLECT, acc = 0, count = 0, err = 0, trunc = 0. Therefore out_valid = 0, out_bcd = 0, out_count = 0, out_err = 0, out_trunc = 0, in_ready = 1.
- All outputs are registered or decoded from state only. There are no combinational paths from in_* or out_ready to any output.
- Latency: out_valid rises on the cycle after the closing digit is accepted.
- Throughput:
  - One digit per cycle within a frame.
  - At least one idle input cycle per word, namely the HOLD cycle. in_ready stays 0 for the whole HOLD stay.
  - With out_ready held at 1, a word takes N+1 cycles for N digits.
- Backpressure: HOLD persists indefinitely while out_ready = 0, and the outputs do not change.
- Reset mid-frame or mid-HOLD discards the partial or pending word with no output.
- in_valid while in HOLD has no effect. Upstream must hold the digit until in_ready.

## Structure

- Package excess3_pkg holds:
  - localparam E3_BIAS = 4'd3, E3_MIN = 4'h3, E3_MAX = 4'hC, BCD_ILLEGAL = 4'hF.
  - typedef enum for the FSM states {COLLECT, HOLD, DRAIN}.
- Sub-module excess3_digit_decode: combinational. Input is a 4-bit code; outputs are a 4-bit BCD value and an illegal flag. It is reusable by the encoder's self-check bench.
- Top level contains the FSM, the accumulator shift register, count, and the sticky err and trunc flags.

## Test plan

- NDIGITS=4, out_ready=1. Send 4'h4, 4'h8, 4'hC (last) on consecutive cycles. Expect one cycle later: out_bcd = 16'h0159, out_count = 3, out_err = 0, out_trunc = 0.
- Send 4'h3, 4'hF (last). Expect out_bcd = 16'h000F, out_count = 2, out_err = 1. The next word 4'h7 (last) must show out_err = 0 and out_bcd = 16'h0004.
- Send 6 digits 4'h4..4'h9 with last on the 6th. Expect a word of 16'h1234 with out_count = 4 and out_trunc = 1. The remaining 2 digits must be absorbed in DRAIN with no further output. The next word 4'hC (last) must give 16'h0009.
- Hold out_ready = 0 for 5 cycles after a word completes. in_ready must be 0 and the outputs must stay constant. Raise out_ready: the word is consumed in 1 cycle and in_ready returns to 1 on the following cycle.
- Pulse rst_n low after 2 digits of a frame. All outputs must return to their reset values immediately. A fresh 4'h3 (last) must then yield 16'h0000 with out_count = 1.
- Random legal streams with random backpressure, checked against an encoder round-trip model. Every word must match, with no loss or duplication.
